// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multi-port register file and its scoreboard:
// default geometry, address/data typedef helpers at the default geometry,
// and the index of the optional hardwired zero register.
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_REGS   = 8;
    localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_NUM_REGS);

    // Register that reads as zero when the zero-register option is enabled.
    localparam int ZERO_REG = 0;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] rf_data_t;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per register. A reservation from decode sets the bit; a
// retiring write from either writeback port clears it. When a reservation
// and a clear hit the same register in one cycle the reservation wins,
// because it belongs to the newer producer.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   reserve_en, reserve_reg  set busy[reserve_reg]
//   clr_en0/1, clr_addr0/1   clear busy[clr_addrN] (retiring writes)
//   busy_vec                 registered scoreboard
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NUM_REGS    = DEFAULT_NUM_REGS,
    parameter  int ZERO_REG_EN = 0,
    localparam int ADDR_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_reg,
    input  logic                  clr_en0,
    input  logic [ADDR_WIDTH-1:0] clr_addr0,
    input  logic                  clr_en1,
    input  logic [ADDR_WIDTH-1:0] clr_addr1,
    output logic [NUM_REGS-1:0]   busy_vec
);

    logic [NUM_REGS-1:0] busy_next;

    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so later statements override earlier ones and no latch
    // is inferred.
    always_comb begin
        busy_next = busy_vec;
        if (clr_en0)    busy_next[clr_addr0]   = 1'b0;
        if (clr_en1)    busy_next[clr_addr1]   = 1'b0;
        // Applied after the clears so a same-cycle reservation survives.
        if (reserve_en) busy_next[reserve_reg] = 1'b1;
        if (ZERO_REG_EN != 0) busy_next[ADDR_WIDTH'(ZERO_REG)] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_vec <= '0;
        else      busy_vec <= busy_next;
    end

endmodule : rf_scoreboard

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
// Two-read / two-write register file with optional write-to-read bypass,
// optional hardwired zero register and a busy scoreboard for RAW hazard
// detection between decode and writeback.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   we0/we1, waddr0/1, wdata0/1 writeback ports; port 1 wins a collision
//   reserve_en, reserve_reg     mark a register busy (issued producer)
//   raddr0/1                    read addresses
//   rdata0/1                    read data (combinational)
//   rbusy0/1                    addressed register has a pending producer
//   busy_vec                    full registered scoreboard
// ---------------------------------------------------------------------------
module register_file_mp
    import rf_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REGS    = DEFAULT_NUM_REGS,
    parameter  int BYPASS_EN   = 1,
    parameter  int ZERO_REG_EN = 0,
    localparam int ADDR_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_reg,
    input  logic [ADDR_WIDTH-1:0] raddr0,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rbusy0,
    output logic                  rbusy1,
    output logic [NUM_REGS-1:0]   busy_vec
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0]          regs [NUM_REGS];
    logic [1:0][ADDR_WIDTH-1:0]     raddr;
    logic                           wr0_ok;
    logic                           wr1_ok;

    // A write takes effect only out of reset and never lands on the zero
    // register; the same qualified enables drive bypass and busy clearing.
    assign wr0_ok = rst && we0 && !(ZERO_REG_EN != 0 && waddr0 == ZERO_ADDR);
    assign wr1_ok = rst && we1 && !(ZERO_REG_EN != 0 && waddr1 == ZERO_ADDR);
    assign raddr  = {raddr1, raddr0};

    // NOTE: the storage array is reset because architectural registers must
    // read 0 immediately on reset. Port 1 is written last so it wins a
    // same-address collision. With the zero register enabled, regs[0] is
    // never written and stays constant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (wr0_ok) regs[waddr0] <= wdata0;
            if (wr1_ok) regs[waddr1] <= wdata1;
        end
    end

    rf_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .reserve_en  (reserve_en),
        .reserve_reg (reserve_reg),
        .clr_en0     (wr0_ok),
        .clr_addr0   (waddr0),
        .clr_en1     (wr1_ok),
        .clr_addr1   (waddr1),
        .busy_vec    (busy_vec)
    );

    // Per read port: stored value, optionally overridden by a same-cycle
    // write (port 1 preferred), then masked for the zero register.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic                  hit0;
        logic                  hit1;
        logic                  resv_hit;
        logic                  is_zero;
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;

        assign hit0     = (BYPASS_EN != 0) && wr0_ok && (waddr0 == raddr[p]);
        assign hit1     = (BYPASS_EN != 0) && wr1_ok && (waddr1 == raddr[p]);
        assign resv_hit = reserve_en && (reserve_reg == raddr[p]);
        assign is_zero  = (ZERO_REG_EN != 0) && (raddr[p] == ZERO_ADDR);

        always_comb begin
            data = regs[raddr[p]];
            busy = busy_vec[raddr[p]];
            if (hit1)      data = wdata1;
            else if (hit0) data = wdata0;
            // A retiring write hides the stale busy bit unless a newer
            // producer is reserving the same register this cycle.
            if ((hit0 || hit1) && !resv_hit) busy = 1'b0;
            if (is_zero) begin
                data = '0;
                busy = 1'b0;
            end
        end
    end

    assign rdata0 = g_rd[0].data;
    assign rdata1 = g_rd[1].data;
    assign rbusy0 = g_rd[0].busy;
    assign rbusy1 = g_rd[1].busy;

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
// Three instances share one stimulus stream:
//   cfg 0: BYPASS_EN=1, ZERO_REG_EN=0 (defaults)
//   cfg 1: BYPASS_EN=0, ZERO_REG_EN=0
//   cfg 2: BYPASS_EN=1, ZERO_REG_EN=1
// Directed scenarios are followed by randomized traffic checked against an
// array/bitmask reference model.
// ---------------------------------------------------------------------------
module tb_register_file_mp;
    import rf_pkg::*;

    localparam int NCFG = 3;
    localparam int DW   = DEFAULT_DATA_WIDTH;
    localparam int NR   = DEFAULT_NUM_REGS;

    logic     clk;
    logic     rst;
    logic     we0, we1, reserve_en;
    rf_addr_t waddr0, waddr1, reserve_reg, raddr0, raddr1;
    rf_data_t wdata0, wdata1;

    rf_data_t          rd0 [NCFG];
    rf_data_t          rd1 [NCFG];
    logic              rb0 [NCFG];
    logic              rb1 [NCFG];
    logic [NR-1:0]     bv  [NCFG];

    rf_data_t          m_reg  [NCFG][NR];
    logic [NR-1:0]     m_busy [NCFG];

    int n_checks = 0;
    int n_errors = 0;

    register_file_mp #(.BYPASS_EN(1), .ZERO_REG_EN(0)) u_byp (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .reserve_en(reserve_en), .reserve_reg(reserve_reg),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rd0[0]), .rdata1(rd1[0]),
        .rbusy0(rb0[0]), .rbusy1(rb1[0]),
        .busy_vec(bv[0])
    );

    register_file_mp #(.BYPASS_EN(0), .ZERO_REG_EN(0)) u_nobyp (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .reserve_en(reserve_en), .reserve_reg(reserve_reg),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rd0[1]), .rdata1(rd1[1]),
        .rbusy0(rb0[1]), .rbusy1(rb1[1]),
        .busy_vec(bv[1])
    );

    register_file_mp #(.BYPASS_EN(1), .ZERO_REG_EN(1)) u_zero (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .reserve_en(reserve_en), .reserve_reg(reserve_reg),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rd0[2]), .rdata1(rd1[2]),
        .rbusy0(rb0[2]), .rbusy1(rb1[2]),
        .busy_vec(bv[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cfg_byp(input int c);
        return c != 1;
    endfunction

    function automatic bit cfg_zero(input int c);
        return c == 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int r = 0; r < NR; r++) m_reg[c][r] = '0;
            m_busy[c] = '0;
        end
    endtask

    // Expected combinational read for one port, from the functional rules.
    task automatic exp_read(input int c, input rf_addr_t ra,
                            output rf_data_t d, output logic b);
        bit z, h0, h1;
        z  = cfg_zero(c);
        d  = m_reg[c][ra];
        b  = m_busy[c][ra];
        h0 = cfg_byp(c) && rst && we0 && waddr0 == ra && !(z && waddr0 == 0);
        h1 = cfg_byp(c) && rst && we1 && waddr1 == ra && !(z && waddr1 == 0);
        if (h1)      d = wdata1;
        else if (h0) d = wdata0;
        if ((h0 || h1) && !(reserve_en && reserve_reg == ra)) b = 1'b0;
        if (z && ra == 0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCFG; c++) begin
            bit z;
            z = cfg_zero(c);
            if (we0 && !(z && waddr0 == 0)) m_reg[c][waddr0] = wdata0;
            if (we1 && !(z && waddr1 == 0)) m_reg[c][waddr1] = wdata1;
            if (we0) m_busy[c][waddr0] = 1'b0;
            if (we1) m_busy[c][waddr1] = 1'b0;
            if (reserve_en) m_busy[c][reserve_reg] = 1'b1;
            if (z) m_busy[c][0] = 1'b0;
        end
    endtask

    task automatic check_reads();
        rf_data_t d;
        logic     b;
        for (int c = 0; c < NCFG; c++) begin
            exp_read(c, raddr0, d, b);
            check($sformatf("cfg%0d rdata0[%0d]", c, raddr0), rd0[c], d);
            check($sformatf("cfg%0d rbusy0[%0d]", c, raddr0), rb0[c], b);
            exp_read(c, raddr1, d, b);
            check($sformatf("cfg%0d rdata1[%0d]", c, raddr1), rd1[c], d);
            check($sformatf("cfg%0d rbusy1[%0d]", c, raddr1), rb1[c], b);
        end
    endtask

    task automatic check_vec();
        for (int c = 0; c < NCFG; c++)
            check($sformatf("cfg%0d busy_vec", c), bv[c], m_busy[c]);
    endtask

    // Inputs are set by the caller between edges; check reads, take the edge,
    // update the model, check the scoreboard just after the edge.
    task automatic tick();
        #1;
        check_reads();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_vec();
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        reserve_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        reserve_reg = '0; raddr0 = 3'd2; raddr1 = '0;
        model_reset();

        // Reset state
        #2;
        check_reads();
        check_vec();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single write: no bypass shows old value, bypass shows new
        we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'hAA; raddr0 = 3'd2;
        #1;
        check("nobyp same-cycle r2", rd0[1], 8'h00);
        check("byp same-cycle r2", rd0[0], 8'hAA);
        tick();
        idle();
        #1;
        check("nobyp after edge r2", rd0[1], 8'hAA);

        // Scoreboard: reserve r5, busy next cycle, write two cycles later
        reserve_en = 1'b1; reserve_reg = 3'd5; raddr0 = 3'd5;
        #1;
        check("rbusy r5 before edge", rb0[0], 1'b0);
        tick();
        idle();
        #1;
        check("rbusy r5 after reserve", rb0[0], 1'b1);
        tick();
        we0 = 1'b1; waddr0 = 3'd5; wdata0 = 8'h5A;
        #1;
        check("byp rbusy r5 on write", rb0[0], 1'b0);
        check("nobyp rbusy r5 on write", rb0[1], 1'b1);
        tick();
        idle();
        #1;
        check("nobyp rbusy r5 after write", rb0[1], 1'b0);
        check("nobyp rdata r5 after write", rd0[1], 8'h5A);

        // Mid-run reset: clears immediately, concurrent write is lost
        reserve_en = 1'b1; reserve_reg = 3'd6;
        tick();
        idle();
        raddr0 = 3'd2;
        #1;
        check("r2 before reset", rd0[1], 8'hAA);
        check("busy r6 before reset", bv[0][6], 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < NCFG; c++) begin
            check($sformatf("cfg%0d r2 in reset", c), rd0[c], 8'h00);
            check($sformatf("cfg%0d busy_vec in reset", c), bv[c], '0);
        end
        we0 = 1'b1; waddr0 = 3'd3; wdata0 = 8'h77;
        @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
        raddr1 = 3'd3;
        #1;
        for (int c = 0; c < NCFG; c++)
            check($sformatf("cfg%0d r3 write lost in reset", c), rd1[c], 8'h00);

        // Bypass plus collision: port 1 wins
        we0 = 1'b1; waddr0 = 3'd3; wdata0 = 8'h11;
        we1 = 1'b1; waddr1 = 3'd3; wdata1 = 8'hFF;
        raddr1 = 3'd3;
        #1;
        check("byp collision same cycle", rd1[0], 8'hFF);
        tick();
        idle();
        #1;
        check("nobyp collision stored", rd1[1], 8'hFF);

        // Reserve/write race on r4: reserve wins, data still written
        reserve_en = 1'b1; reserve_reg = 3'd4;
        we0 = 1'b1; waddr0 = 3'd4; wdata0 = 8'h3C; raddr0 = 3'd4;
        tick();
        idle();
        #1;
        check("race busy r4", bv[0][4], 1'b1);
        check("race rbusy r4", rb0[0], 1'b1);
        check("race data r4", rd0[1], 8'h3C);

        // Zero register
        we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'hFF;
        reserve_en = 1'b1; reserve_reg = 3'd0; raddr0 = 3'd0;
        #1;
        check("zero rdata same cycle", rd0[2], 8'h00);
        check("nonzero byp r0 same cycle", rd0[0], 8'hFF);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("zero rdata r0", rd0[2], 8'h00);
            check("zero rbusy r0", rb0[2], 1'b0);
            check("zero busy_vec[0]", bv[2][0], 1'b0);
            tick();
        end
        check("nonzero busy_vec[0]", bv[0][0], 1'b1);

        // Randomized traffic; small address space makes collisions frequent
        for (int n = 0; n < 400; n++) begin
            we0         = 1'($urandom_range(0, 1));
            we1         = 1'($urandom_range(0, 1));
            reserve_en  = ($urandom_range(0, 2) == 0);
            waddr0      = 3'($urandom_range(0, NR - 1));
            waddr1      = 3'($urandom_range(0, NR - 1));
            reserve_reg = 3'($urandom_range(0, NR - 1));
            raddr0      = 3'($urandom_range(0, NR - 1));
            raddr1      = 3'($urandom_range(0, NR - 1));
            wdata0      = 8'($urandom);
            wdata1      = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_register_file_mp

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the pipelined datapath. It has two read ports, two write ports, optional write-to-read bypass, and an optional hardwired zero register. A per-register busy scoreboard lets decode detect read-after-write hazards until the producing write retires. It replaces the single-write 8-bit register file and sits between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_WIDTH, 8, register width in bits
- NUM_REGS, 8, register count (power of two, ≥2); ADDR_WIDTH = $clog2(NUM_REGS)
- BYPASS_EN, 1, 1 = a same-cycle write is visible on the read ports
- ZERO_REG_EN, 0, 1 = register 0 always reads 0, ignores writes and reservations

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- we0 / we1  in  1  write enables, ports 0 and 1
- waddr0 / waddr1  in  ADDR_WIDTH  write addresses
- wdata0 / wdata1  in  DATA_WIDTH  write data
- reserve_en  in  1  mark reserve_reg busy
- reserve_reg  in  ADDR_WIDTH  register being reserved by an issued instruction
- raddr0 / raddr1  in  ADDR_WIDTH  read addresses
- rdata0 / rdata1  out  DATA_WIDTH  read data (combinational)
- rbusy0 / rbusy1  out  1  addressed register has a pending producer (combinational)
- busy_vec  out  NUM_REGS  full scoreboard, registered

## Operation
- Reset (rst=0, asynchronous): all registers are 0 and busy_vec is 0. While rst=0, writes and reservations are ignored. Release takes effect at the next clk edge.
- Write: on a rising edge with weN=1, reg[waddrN] <= wdataN.
- Write collision: we0 and we1 both 1 with the same address means port 1 wins. Both writes still clear busy on that address.
- Read: rdataN = reg[raddrN] for the stored value.
- Bypass (BYPASS_EN=1): if weK=1 and waddrK==raddrN, rdataN = wdataK. When both ports match, port 1's data is used.
- Busy clear: a write via weK clears busy[waddrK] at the same edge.
- Busy set: reserve_en=1 sets busy[reserve_reg].
- Reserve and write to the same register in the same cycle: reserve wins, so busy=1 after the edge. This tracks the newer producer.
- rbusyN = busy_vec[raddrN], except with BYPASS_EN=1 a same-cycle write to raddrN forces rbusyN=0 unless reserve_en targets the same register.
- ZERO_REG_EN=1: register 0 has no storage. rdata reads 0 and rbusy reads 0. busy_vec[0] is tied to 0. A write to register 0 is dropped, including its bypass.
- Widths: addresses are unsigned. There is no out-of-range case because NUM_REGS is a power of two.

## Timing
- Write-to-read latency: 0 cycles with BYPASS_EN=1, 1 cycle (next edge) with BYPASS_EN=0.
- Reserve-to-rbusy latency: 1 cycle. rbusy is asserted from the edge after reserve_en.
- Write-to-busy-clear: same edge as the write. The next cycle shows rbusy=0.
- Read ports and rbusy are combinational. There are no read-side flops and no read enable.
- Reset asserted mid-operation clears all state immediately, with no waiting for clk. A write issued in the same cycle is lost.

## Structure
- Shared package rf_pkg holds default DATA_WIDTH/NUM_REGS, the `rf_addr_t` / `rf_data_t` typedef helpers and the ZERO_REG index constant. It is included alongside defines.sv.
- Sub-module rf_scoreboard (clk, rst, reserve, two clear ports, busy_vec) holds the busy bits and the reserve-wins rule.
- The top level holds the storage array, write priority, bypass muxes and zero-register masking.

## Test plan
- Reset: drive rst=0 mid-run after writing 8'hAA to r2 -> rdata0(raddr0=2)=8'h00 and busy_vec=0 immediately, before any edge.
- Single write, BYPASS_EN=0: we0=1, waddr0=2, wdata0=8'hAA, raddr0=2 -> rdata0 old value (0) in the same cycle, 8'hAA after the edge.
- Bypass plus collision, BYPASS_EN=1: we0 writes r3←8'h11 and we1 writes r3←8'hFF in one cycle, raddr1=3 -> rdata1=8'hFF that cycle and r3=8'hFF after the edge.
- Scoreboard: reserve r5, then next cycle raddr0=5 -> rbusy0=1. Write r5←8'h5A two cycles later -> rbusy0=0 and rdata0=8'h5A from then on.
- Reserve/write race: reserve_en on r4 and we0 to r4 in the same cycle -> busy_vec[4]=1 after the edge, r4 holds the written data.
- ZERO_REG_EN=1: write 8'hFF to r0 and reserve r0 -> rdata=0, rbusy=0, busy_vec[0]=0 on all following cycles.
